// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver.
// State encoding and frame width constant.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin.
// Resets to 1 so an idle line never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling, 1-cycle rx_d strobe.
// Define UART_RX_FRAME_ERR_EN to add the frame_err strobe port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_per_bit = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic       rx_d,
  output logic [7:0] rx_rec
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int CW = $clog2(clk_per_bit);
  localparam logic [CW-1:0] MID  = CW'((clk_per_bit - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(clk_per_bit - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_line;

  rx_state_e state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_rec_q, rx_rec_d;
  logic rx_d_q, rx_d_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic ferr_q, ferr_d;
`endif

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_serial),
    .q    (rx_line)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_rec_d  = rx_rec_q;
    rx_d_d    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_line) begin
          state_d = START;
        end
      end
      START: begin
        if (clk_cnt_q == MID) begin
          clk_cnt_d = '0;
          // still low at mid start bit, else a glitch
          state_d   = rx_line ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          shift_d[bit_idx_q] = rx_line;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rx_line) begin
            rx_d_d   = 1'b1;
            rx_rec_d = shift_q;
          end else begin
`ifdef UART_RX_FRAME_ERR_EN
            ferr_d = 1'b1;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_rec_q  <= '0;
      rx_d_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_rec_q  <= rx_rec_d;
      rx_d_q    <= rx_d_d;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
    end
  end

  assign frame_err = ferr_q;
`endif

  assign rx_d   = rx_d_q;
  assign rx_rec = rx_rec_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at a reduced bit period.
// Honours UART_RX_FRAME_ERR_EN for the frame_err port.
module tb_uart_rx;

  localparam int CPB = 434;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_serial = 1'b1;
  logic rx_d;
  logic [7:0] rx_rec;
`ifdef UART_RX_FRAME_ERR_EN
  logic frame_err;
`endif

  always #10 clk = ~clk;

  uart_rx #(
    .clk_per_bit(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_serial(rx_serial),
    .rx_d     (rx_d),
    .rx_rec   (rx_rec)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses = 0;
  int ferrs = 0;
  logic rx_d_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_d) begin
      check("rx_d_one_cycle", 32'(rx_d_prev), 32'd0);
      pulses++;
      check("rx_d_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check("rx_rec_byte", 32'(rx_rec), 32'(exp_b));
      end
    end
    rx_d_prev = rx_d;
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err) ferrs++;
`endif
  end

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    if (stop) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx_serial = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = 1'b1;
  endtask

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int f0;
    logic [7:0] c3;

    repeat (5) @(negedge clk);
    check("reset_rx_d", 32'(rx_d), 32'd0);
    check("reset_rx_rec", 32'(rx_rec), 32'h00);
    rst_n = 1'b1;
    idle(100);

    p0 = pulses;
    send_byte(8'hA5, 1'b1);
    idle(2 * CPB);
    check("pulses_a5", 32'(pulses - p0), 32'd1);
    check("hold_a5", 32'(rx_rec), 32'hA5);

    p0 = pulses;
    send_byte(8'h3C, 1'b1);
    idle(2 * CPB);
    send_byte(8'hF0, 1'b1);
    idle(2 * CPB);
    check("pulses_3c_f0", 32'(pulses - p0), 32'd2);
    check("hold_f0", 32'(rx_rec), 32'hF0);

    p0 = pulses;
    rx_serial = 1'b0;
    repeat (100) @(negedge clk);
    idle(3 * CPB);
    check("pulses_glitch", 32'(pulses - p0), 32'd0);
    check("hold_glitch", 32'(rx_rec), 32'hF0);

    p0 = pulses;
    f0 = ferrs;
    send_byte(8'h55, 1'b0);
    idle(2 * CPB);
    check("pulses_bad_stop", 32'(pulses - p0), 32'd0);
    check("hold_bad_stop", 32'(rx_rec), 32'hF0);
`ifdef UART_RX_FRAME_ERR_EN
    check("frame_err_cnt", 32'(ferrs - f0), 32'd1);
`endif

    p0 = pulses;
    f0 = ferrs;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(2 * CPB);
    check("pulses_b2b", 32'(pulses - p0), 32'd2);
    check("hold_ff", 32'(rx_rec), 32'hFF);
`ifdef UART_RX_FRAME_ERR_EN
    check("frame_err_none", 32'(ferrs - f0), 32'd0);
`endif

    p0 = pulses;
    c3 = 8'hC3;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = c3[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = c3[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rx_rec", 32'(rx_rec), 32'h00);
    check("abort_rx_d", 32'(rx_d), 32'd0);
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    check("pulses_abort", 32'(pulses - p0), 32'd0);
    check("hold_abort", 32'(rx_rec), 32'h00);

    p0 = pulses;
    send_byte(8'h81, 1'b1);
    idle(2 * CPB);
    check("pulses_81", 32'(pulses - p0), 32'd1);
    check("hold_81", 32'(rx_rec), 32'h81);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
